// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha20 datapath: the keystream generator,
// the XOR stage and the plaintext block assembler.
//   DATA_SIZE_DEF / NUM_MATRICES_DEF / NO_REG_DEF : default element and block geometry
//   elem_t / blk_t : one element, and one block of NO_REG_DEF elements
//   CTR_INIT_AEAD  : first block counter of an AEAD encryption
//   asm_state_e    : assembler states
package chacha_pkg;

    localparam int DATA_SIZE_DEF    = 8;
    localparam int NUM_MATRICES_DEF = 1;
    localparam int NO_REG_DEF       = 64 * NUM_MATRICES_DEF;
    localparam int CTR_INIT_AEAD    = 1;

    typedef logic [DATA_SIZE_DEF-1:0] elem_t;
    typedef elem_t                    blk_t [0:NO_REG_DEF-1];

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } asm_state_e;

endpackage

// File: rtl/pt_block_assembler.sv
// Packs a byte-serial plaintext stream into NO_REG-element blocks for the
// keystream XOR stage, zero-padding a short final block, and tags each block
// with its length, end-of-message flag and ChaCha20 block counter.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_data/s_valid/s_last : input byte stream, s_last marks the final byte
//   s_ready               : byte accepted this cycle when s_valid is also high
//   char_in               : assembled block (unused tail is zero)
//   blk_valid/blk_ready   : block handshake toward the XOR stage
//   blk_len               : valid elements in the block, 1..NO_REG
//   blk_last              : block ends the message
//   blk_ctr               : block counter for this block
//   ctr_ovf               : sticky, set when the counter wraps inside a message
module pt_block_assembler
    import chacha_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int NUM_MATRICES = NUM_MATRICES_DEF,
    parameter int NO_REG       = 64 * NUM_MATRICES,
    parameter int CTR_W        = 32,
    parameter int CTR_INIT     = CTR_INIT_AEAD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_SIZE-1:0]        s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [DATA_SIZE-1:0]        char_in [0:NO_REG-1],
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [$clog2(NO_REG+1)-1:0] blk_len,
    output logic                        blk_last,
    output logic [CTR_W-1:0]            blk_ctr,
    output logic                        ctr_ovf
);

    localparam int                IDX_W    = $clog2(NO_REG);
    localparam int                LEN_W    = $clog2(NO_REG+1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NO_REG-1);
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'(CTR_INIT);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};

    asm_state_e       state_q, state_d;
    logic [IDX_W-1:0] wr_idx;
    logic             accept, fin, hs;

    assign s_ready   = (state_q == FILL);
    assign blk_valid = (state_q == HOLD);
    assign accept    = s_valid && s_ready;
    // Block closes on the byte that fills the last slot or ends the message.
    assign fin       = accept && ((wr_idx == LAST_IDX) || s_last);
    assign hs        = blk_valid && blk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (fin) state_d = HOLD;
            HOLD:    if (hs)  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            blk_len  <= '0;
            blk_last <= 1'b0;
            blk_ctr  <= CTR_RST;
            ctr_ovf  <= 1'b0;
            for (int i = 0; i < NO_REG; i++) char_in[i] <= '0;
        end else begin
            if (accept) begin
                char_in[wr_idx] <= s_data;
                if (wr_idx != LAST_IDX) wr_idx <= wr_idx + IDX_W'(1);
                if (fin) begin
                    blk_len  <= LEN_W'(wr_idx) + LEN_W'(1);
                    blk_last <= s_last;
                end
            end
            // Buffer is cleared on consume so a short next block is already zero-padded.
            if (hs) begin
                wr_idx   <= '0;
                blk_len  <= '0;
                blk_last <= 1'b0;
                for (int i = 0; i < NO_REG; i++) char_in[i] <= '0;
                if (blk_last) begin
                    blk_ctr <= CTR_RST;
                end else begin
                    blk_ctr <= blk_ctr + CTR_W'(1);
                    if (blk_ctr == CTR_MAX) ctr_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pt_block_assembler.md
Name: pt_block_assembler

Overview:
- Upstream neighbour of the keystream XOR stage.
- Collects a byte-serial plaintext stream into one NO_REG-byte block (char_in) and zero-pads short final blocks.
- Presents the block with a valid/ready handshake; the ready side is driven by whoever owns XOR_READY.
- Tracks the ChaCha20 block counter per message, so the keystream generator and XOR stage see matching block, length and counter.

Parameters:
- DATA_SIZE, 8, bits per element.
- NUM_MATRICES, 1, ChaCha state matrices per block.
- NO_REG, 64*NUM_MATRICES, elements per block.
- CTR_W, 32, block-counter width.
- CTR_INIT, 1, counter value for the first block of each message (AEAD encryption starts at 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_SIZE  plaintext byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  byte is the final byte of the message.
- s_ready  out  1  assembler accepts a byte this cycle.
- char_in  out  [DATA_SIZE-1:0] x [0:NO_REG-1]  assembled block, zero-padded.
- blk_valid  out  1  block complete and stable.
- blk_ready  in  1  downstream consumes block (XOR_READY source).
- blk_len  out  $clog2(NO_REG+1)  valid bytes in block, 1..NO_REG.
- blk_last  out  1  block ends the message.
- blk_ctr  out  CTR_W  ChaCha block counter for this block.
- ctr_ovf  out  1  sticky counter-wrap flag.

Behaviour:
Reset (rst_n=0, async):
- state=FILL, wr_idx=0, every char_in element=0.
- blk_valid=0, blk_len=0, blk_last=0, blk_ctr=CTR_INIT, ctr_ovf=0.
- Any partial block is discarded; s_ready=1 on the first edge after release.

States: FILL, HOLD.
- s_ready = (state==FILL). blk_valid = (state==HOLD).

FILL:
- A byte is accepted when s_valid&&s_ready. On acceptance: char_in[wr_idx]<=s_data and wr_idx<=wr_idx+1.
- If the accepted byte has wr_idx==NO_REG-1 or s_last=1:
  - next state is HOLD;
  - blk_len<=wr_idx+1 and blk_last<=s_last;
  - wr_idx is not incremented past NO_REG-1.
- s_valid while s_ready=0 has no effect and the byte is not consumed.

HOLD:
- char_in, blk_len, blk_last and blk_ctr are held stable until the handshake.
- Handshake when blk_valid&&blk_ready. In that same edge:
  - all char_in are cleared to 0 and wr_idx<=0;
  - state<=FILL; blk_len and blk_last are cleared;
  - blk_ctr<=CTR_INIT if blk_last=1, else blk_ctr+1.
- blk_ready while blk_valid=0 is ignored.

Latency and throughput:
- blk_valid rises the cycle after the final byte is accepted.
- After the handshake, s_ready rises the next cycle; there is no same-cycle refill.
- Full-rate throughput is NO_REG+1 cycles per block with blk_ready held high.

Boundaries:
- s_last on byte NO_REG: blk_len=NO_REG, blk_last=1.
- s_last on the first byte: blk_len=1, elements 1..NO_REG-1 are 0.
- An empty message is impossible because s_last always accompanies a byte.

Counter overflow:
- Handshake on a non-last block with blk_ctr=2^CTR_W-1: blk_ctr wraps to 0 and ctr_ovf<=1.
- ctr_ovf is sticky until reset.

Reset mid-HOLD or mid-FILL returns all outputs to their reset values asynchronously.

Decomposition:
- Shared package chacha_pkg holds:
  - DATA_SIZE and NO_REG defaults;
  - the byte/element typedef and the block array typedef (reused by the XOR and keystream stages);
  - CTR_INIT_AEAD=1;
  - the state enum {FILL, HOLD}.
- No sub-module. Buffer, index counter and block counter are one flat always_ff plus a small combinational output.

Test Plan:
- Exact block: 64-byte message 0x00..0x3F with s_last on byte 64 and blk_ready=1 → one block; char_in[i]=i, blk_len=64, blk_last=1, blk_ctr=1, blk_valid 1 cycle after last accept.
- Multi-block: 100-byte message 0xA5 → block0 len=64, last=0, ctr=1; block1 len=36, last=1, ctr=2; char_in[36..63]=0. A following message restarts at ctr=1.
- Backpressure: hold blk_ready=0 for 10 cycles in HOLD while s_valid=1 → s_ready=0, char_in/len/ctr unchanged, no byte lost; first byte accepted 1 cycle after the blk_ready pulse.
- Single byte: 0x5C with s_last → blk_len=1, char_in[0]=0x5C, rest 0.
- Reset mid-fill: reset after 20 bytes, then send a 64-byte message → output contains only the new data, ctr=1, no residue from the aborted block.
- Overflow (CTR_W=4, CTR_INIT=14): 3-block message → ctr 14, 15, 0; ctr_ovf=1 after the second handshake and still 1 after the message.
